// File: rtl/la_pkg.sv
// Shared state encodings and default widths for the trigger_capture logic analyser.
// Optional edge triggering is enabled by defining TRIG_EDGE_EN.
package la_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/trig_match.sv
// Combinational trigger qualifier: level pattern match plus, with TRIG_EDGE_EN,
// per-channel rise/fall conditions against the previous valid sample.
module trig_match #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] prev,
    input  logic              prev_valid,
    input  logic [DATA_W-1:0] mask,
    input  logic [DATA_W-1:0] value,
    input  logic [DATA_W-1:0] rise,
    input  logic [DATA_W-1:0] fall,
    output logic              hit
);

    logic level_ok;

    assign level_ok = ((data ^ value) & mask) == '0;

`ifdef TRIG_EDGE_EN
    logic rise_ok;
    logic fall_ok;
    logic edge_ok;

    assign rise_ok = ((~prev & data) & rise) == rise;
    assign fall_ok = ((prev & ~data) & fall) == fall;
    // No edge can be seen without a previous sample, so the first sample after arm never qualifies.
    assign edge_ok = ((rise | fall) == '0) || (prev_valid && rise_ok && fall_ok);
    assign hit     = level_ok && edge_ok;
`else
    logic unused_edge;

    assign unused_edge = ^{prev, prev_valid, rise, fall};
    assign hit         = level_ok;
`endif

endmodule

// File: rtl/trigger_capture.sv
// Pre/post-trigger sample capture controller driving a circular buffer RAM write port.
// Define TRIG_EDGE_EN to add per-channel rise/fall trigger conditions.
module trigger_capture
    import la_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [DATA_W-1:0] trig_rise,
    input  logic [DATA_W-1:0] trig_fall,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [ADDR_W-1:0] post_count,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [2:0]        state,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr
);

    state_t            st;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_inc;
    logic [ADDR_W-1:0] cfg_pre;
    logic [ADDR_W-1:0] cfg_post;
    logic [DATA_W-1:0] cfg_mask;
    logic [DATA_W-1:0] cfg_value;
    logic              capture;
    logic              hit;

    assign state   = st;
    assign cnt_inc = cnt + 1'b1;
    assign capture = in_valid && !abort && (st == ST_PRE || st == ST_WAIT || st == ST_POST);

`ifdef TRIG_EDGE_EN
    logic [DATA_W-1:0] cfg_rise;
    logic [DATA_W-1:0] cfg_fall;
    logic [DATA_W-1:0] prev;
    logic              prev_valid;

    trig_match #(.DATA_W(DATA_W)) u_match (
        .data       (in_data),
        .prev       (prev),
        .prev_valid (prev_valid),
        .mask       (cfg_mask),
        .value      (cfg_value),
        .rise       (cfg_rise),
        .fall       (cfg_fall),
        .hit        (hit)
    );
`else
    trig_match #(.DATA_W(DATA_W)) u_match (
        .data       (in_data),
        .prev       ('0),
        .prev_valid (1'b0),
        .mask       (cfg_mask),
        .value      (cfg_value),
        .rise       (trig_rise),
        .fall       (trig_fall),
        .hit        (hit)
    );
`endif

    // NOTE: all state here is sequential, so every assignment is non-blocking; blocking
    // assignments would let later statements see half-updated values within one edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st        <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            cfg_pre   <= '0;
            cfg_post  <= '0;
            cfg_mask  <= '0;
            cfg_value <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            triggered <= 1'b0;
            done      <= 1'b0;
            trig_addr <= '0;
`ifdef TRIG_EDGE_EN
            cfg_rise   <= '0;
            cfg_fall   <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
`endif
        end else begin
            // Every valid sample in an active state is written, even on the cycle it causes a transition.
            wr_en <= capture;
            if (capture) begin
                wr_data <= in_data;
                wr_addr <= ptr;
                ptr     <= ptr + 1'b1;
            end
`ifdef TRIG_EDGE_EN
            if (capture && st != ST_POST) begin
                prev       <= in_data;
                prev_valid <= 1'b1;
            end
`endif
            if (abort) begin
                st        <= ST_IDLE;
                triggered <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            st        <= ST_PRE;
                            ptr       <= '0;
                            wr_addr   <= '0;
                            cnt       <= '0;
                            triggered <= 1'b0;
                            done      <= 1'b0;
                            cfg_pre   <= pre_count;
                            cfg_post  <= post_count;
                            cfg_mask  <= trig_mask;
                            cfg_value <= trig_value;
`ifdef TRIG_EDGE_EN
                            cfg_rise   <= trig_rise;
                            cfg_fall   <= trig_fall;
                            prev_valid <= 1'b0;
`endif
                        end
                    end
                    ST_PRE: begin
                        if (in_valid) cnt <= cnt_inc;
                        if (cfg_pre == '0 || (in_valid && cnt_inc == cfg_pre)) begin
                            st  <= ST_WAIT;
                            cnt <= '0;
                        end
                    end
                    ST_WAIT: begin
                        if (in_valid && hit) begin
                            trig_addr <= ptr;
                            triggered <= 1'b1;
                            st        <= ST_POST;
                            cnt       <= '0;
                        end
                    end
                    ST_POST: begin
                        if (in_valid) cnt <= cnt_inc;
                        if (cfg_post == '0 || (in_valid && cnt_inc == cfg_post)) begin
                            st   <= ST_DONE;
                            done <= 1'b1;
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trigger_capture.sv
// Directed self-checking bench for trigger_capture (ADDR_W=4 so wrap-around is reachable).
// Expectations for the edge-trigger case follow TRIG_EDGE_EN.
module tb_trigger_capture;

    localparam int AW = 4;
    localparam int DW = 8;

`ifdef TRIG_EDGE_EN
    localparam int EDGE_TRIG_ADDR = 3;
    localparam int EDGE_WRITES    = 4;
`else
    localparam int EDGE_TRIG_ADDR = 0;
    localparam int EDGE_WRITES    = 2;
`endif

    logic          clk;
    logic          resetn;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          arm;
    logic          abort;
    logic [DW-1:0] trig_mask;
    logic [DW-1:0] trig_value;
    logic [DW-1:0] trig_rise;
    logic [DW-1:0] trig_fall;
    logic [AW-1:0] pre_count;
    logic [AW-1:0] post_count;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [2:0]    state;
    logic          triggered;
    logic          done;
    logic [AW-1:0] trig_addr;

    int n_checks = 0;
    int n_bad    = 0;

    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];

    trigger_capture #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .arm        (arm),
        .abort      (abort),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .trig_rise  (trig_rise),
        .trig_fall  (trig_fall),
        .pre_count  (pre_count),
        .post_count (post_count),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .state      (state),
        .triggered  (triggered),
        .done       (done),
        .trig_addr  (trig_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port log, sampled just before each rising edge updates the outputs.
    always @(posedge clk) begin
        if (resetn && wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d);
        in_valid = v;
        in_data  = d;
        @(negedge clk);
    endtask

    task automatic do_arm(input logic [AW-1:0] pre, input logic [AW-1:0] post,
                          input logic [DW-1:0] mask, input logic [DW-1:0] value,
                          input logic [DW-1:0] rise);
        pre_count  = pre;
        post_count = post;
        trig_mask  = mask;
        trig_value = value;
        trig_rise  = rise;
        trig_fall  = '0;
        in_valid   = 1'b0;
        arm        = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        resetn = 1'b0; in_data = '0; in_valid = 1'b0; arm = 1'b0; abort = 1'b0;
        trig_mask = '0; trig_value = '0; trig_rise = '0; trig_fall = '0;
        pre_count = '0; post_count = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_trig", triggered, 0);
        check("rst_done", done, 0);
        check("rst_trig_addr", trig_addr, 0);
        resetn = 1'b1;
        step(1, 8'h77);
        check("idle_no_write", wr_en, 0);

        // pre=4 post=3, trigger on bit0 set; counting data; config changes after arm are ignored
        do_arm(4, 3, 8'h01, 8'h01, 8'h00);
        check("t1_armed", state, 1);
        pre_count = 4'd7; trig_value = 8'h00;
        for (int i = 0; i < 12; i++) begin
            step(1, DW'(i));
            if (i == 3) check("t1_wait", state, 2);
            if (i == 4) check("t1_trig_lo", triggered, 0);
            if (i == 5) begin
                check("t1_trig_hi", triggered, 1);
                check("t1_post", state, 3);
            end
        end
        step(0, 0);
        check("t1_writes", wa_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (wa_q.size() > i) begin
                check($sformatf("t1_addr%0d", i), wa_q[i], i);
                check($sformatf("t1_data%0d", i), wd_q[i], i);
            end
        end
        check("t1_trig_addr", trig_addr, 5);
        check("t1_done", done, 1);
        check("t1_state", state, 4);

        // Wrap-around: pre=2, exact match 0xAA at sample 20
        do_arm(2, 1, 8'hFF, 8'hAA, 8'h00);
        check("t2_rearm_done", done, 0);
        check("t2_rearm_trig", triggered, 0);
        for (int i = 0; i < 24; i++) step(1, (i == 20) ? 8'hAA : DW'(i));
        step(0, 0);
        check("t2_writes", wa_q.size(), 22);
        if (wa_q.size() > 20) begin
            check("t2_addr15", wa_q[15], 15);
            check("t2_wrap", wa_q[16], 0);
            check("t2_trig_data", wd_q[20], 8'hAA);
        end
        check("t2_trig_addr", trig_addr, 4);
        check("t2_done", done, 1);

        // Abort two cycles into POST
        do_arm(1, 5, 8'hFF, 8'h33, 8'h00);
        step(1, 8'h00);
        step(1, 8'h33);
        check("t3_post", state, 3);
        step(1, 8'h10);
        step(1, 8'h11);
        abort = 1'b1;
        step(1, 8'h12);
        abort = 1'b0;
        check("t3_idle", state, 0);
        check("t3_no_wr", wr_en, 0);
        check("t3_done", done, 0);
        check("t3_trig", triggered, 0);
        repeat (3) step(1, 8'h13);
        check("t3_writes", wa_q.size(), 4);

        // arm and abort together in IDLE: abort wins
        arm = 1'b1; abort = 1'b1;
        step(0, 0);
        arm = 1'b0; abort = 1'b0;
        check("t4_state", state, 0);
        step(1, 8'h01);
        check("t4_no_wr", wr_en, 0);

        // pre=0 post=0 mask=0: a single sample triggers and completes
        do_arm(0, 0, 8'h00, 8'h00, 8'h00);
        check("t5_pre", state, 1);
        step(0, 0);
        check("t5_wait", state, 2);
        step(1, 8'h5A);
        check("t5_post", state, 3);
        check("t5_trig_addr", trig_addr, 0);
        check("t5_trig", triggered, 1);
        step(0, 0);
        check("t5_done", done, 1);
        check("t5_state", state, 4);
        step(0, 0);
        check("t5_writes", wa_q.size(), 1);
        if (wd_q.size() > 0) check("t5_data", wd_q[0], 8'h5A);

        // Rising-edge on ch1 with level mask off: ch1 sequence 1,1,0,1
        do_arm(0, 0, 8'h00, 8'h00, 8'h02);
        step(0, 0);
        step(1, 8'h02);
        step(1, 8'h02);
        step(1, 8'h00);
`ifdef TRIG_EDGE_EN
        check("t6_no_early", triggered, 0);
`endif
        step(1, 8'h02);
        step(0, 0);
        step(0, 0);
        check("t6_trig_addr", trig_addr, EDGE_TRIG_ADDR);
        check("t6_writes", wa_q.size(), EDGE_WRITES);
        check("t6_done", done, 1);

        // Reset mid-capture returns to IDLE with nothing resumed
        do_arm(3, 3, 8'hFF, 8'hEE, 8'h00);
        step(1, 8'h01);
        step(1, 8'h02);
        #2 resetn = 1'b0;
        #1;
        check("t7_rst_state", state, 0);
        check("t7_rst_wr_en", wr_en, 0);
        check("t7_rst_addr", wr_addr, 0);
        @(negedge clk);
        wa_q.delete();
        wd_q.delete();
        resetn = 1'b1;
        repeat (3) step(1, 8'hEE);
        check("t7_idle", state, 0);
        check("t7_writes", wa_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
